// File: rtl/nvram_sd_sync.sv
// nvram_sd_sync
//   Backup-RAM save/load sequencer between the core's dual-port NVRAM and the
//   hps_io SD sector interface. It moves 2^SECTOR_BITS sectors of 512 bytes,
//   one sector at a time, in either direction. It also tracks whether the
//   NVRAM is dirty, can autosave when the OSD opens, aborts on a per-sector
//   ack timeout, and arbitrates between load and save requests.
//   NVRAM port B address is {sd_lba[SECTOR_BITS-1:0], sd_buff_addr}. That
//   address is formed outside this block.
//
// Ports
//   clk_sys    : system clock
//   reset      : synchronous, active-high reset
//   bk_ena     : writable save image mounted; requests are ignored when low
//   mount_done : 1-cycle pulse after ROM download with a non-empty save image (auto-load)
//   load_req   : level; a rising edge requests a load
//   save_req   : level; a rising edge requests a save
//   osd_open   : OSD visible level; a rising edge is the autosave trigger
//   nv_we      : core write strobe to NVRAM port A
//   sd_ack     : hps_io sector acknowledge
//   sd_lba     : current sector number
//   sd_rd      : sector read request (load direction)
//   sd_wr      : sector write request (save direction)
//   busy       : transfer in progress
//   loading    : load in progress (the top ORs this into core reset)
//   dirty      : NVRAM modified since the last load, or since the last save started
//   err        : sticky ack-timeout flag, cleared by the next transfer start

module nvram_sd_sync #(
  parameter int          SECTOR_BITS = 6,
  parameter int          AUTOSAVE    = 1,
  parameter logic [23:0] TIMEOUT     = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        mount_done,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        osd_open,
  input  logic        nv_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic        loading,
  output logic        dirty,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [1:0]             state_reg;
  logic [SECTOR_BITS-1:0] lba_reg;
  logic [23:0]            tmo_cnt_reg;
  logic                   dir_load_reg;
  logic                   sd_rd_reg, sd_wr_reg, loading_reg, dirty_reg, err_reg;
  logic                   load_prev_reg, save_prev_reg, osd_prev_reg, ack_prev_reg;

  logic load_lvl, save_lvl;
  logic load_edge, save_edge, osd_edge, ack_rise, ack_fall;
  logic idle, start_load, start_save, last_sector, tmo_hit;

  // Requests are gated by bk_ena before edge detection. Because of this,
  // raising bk_ena while a request level is already high is treated as a new request.
  assign load_lvl  = load_req & bk_ena;
  assign save_lvl  = save_req & bk_ena;
  assign load_edge = load_lvl & ~load_prev_reg;
  assign save_edge = save_lvl & ~save_prev_reg;
  assign osd_edge  = osd_open & ~osd_prev_reg;
  assign ack_rise  = sd_ack & ~ack_prev_reg;
  assign ack_fall  = ~sd_ack & ack_prev_reg;

  assign idle        = (state_reg == ST_IDLE);
  // A load always wins over a save that is decided in the same cycle.
  assign start_load  = idle & ((mount_done & bk_ena) | load_edge);
  assign start_save  = idle & ~start_load &
                       (save_edge | ((AUTOSAVE != 0) & osd_edge & dirty_reg & bk_ena));
  assign last_sector = &lba_reg;
  assign tmo_hit     = (tmo_cnt_reg == TIMEOUT - 24'd1);

  // Previous-level registers are loaded during reset as well. As a result, a
  // level that is already high when reset is released does not look like an edge.
  always_ff @(posedge clk_sys) begin
    load_prev_reg <= load_lvl;
    save_prev_reg <= save_lvl;
    osd_prev_reg  <= osd_open;
    ack_prev_reg  <= sd_ack;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      lba_reg      <= '0;
      tmo_cnt_reg  <= '0;
      dir_load_reg <= 1'b0;
      sd_rd_reg    <= 1'b0;
      sd_wr_reg    <= 1'b0;
      loading_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_load | start_save) begin
            state_reg    <= ST_REQ;
            lba_reg      <= '0;
            tmo_cnt_reg  <= '0;
            err_reg      <= 1'b0;
            dir_load_reg <= start_load;
            sd_rd_reg    <= start_load;
            sd_wr_reg    <= ~start_load;
            loading_reg  <= start_load;
          end
        end
        ST_REQ: begin
          // An ack that arrives in the timeout cycle itself still counts.
          if (ack_rise) begin
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
            state_reg <= ST_XFER;
          end else if (tmo_hit) begin
            sd_rd_reg   <= 1'b0;
            sd_wr_reg   <= 1'b0;
            err_reg     <= 1'b1;
            loading_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 24'd1;
          end
        end
        ST_XFER: begin
          // hps_io may hold ack high for the whole buffer transfer, so there is no timeout here.
          if (ack_fall) begin
            if (last_sector) begin
              state_reg   <= ST_IDLE;
              loading_reg <= 1'b0;
            end else begin
              lba_reg     <= lba_reg + SECTOR_BITS'(1);
              tmo_cnt_reg <= '0;
              sd_rd_reg   <= dir_load_reg;
              sd_wr_reg   <= ~dir_load_reg;
              state_reg   <= ST_REQ;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Precedence of the dirty update:
  //   1. A core write has top priority. It wins over the clear that happens
  //      at save start, and writes made during a save leave the image dirty.
  //   2. Writes made during a load are the load itself, so they are ignored.
  always_ff @(posedge clk_sys) begin
    if (reset)
      dirty_reg <= 1'b0;
    else if (nv_we & ~loading_reg)
      dirty_reg <= 1'b1;
    else if (start_save)
      dirty_reg <= 1'b0;
    else if ((state_reg == ST_XFER) & ack_fall & last_sector & dir_load_reg)
      dirty_reg <= 1'b0;
  end

  assign sd_lba  = {{(32-SECTOR_BITS){1'b0}}, lba_reg};
  assign sd_rd   = sd_rd_reg;
  assign sd_wr   = sd_wr_reg;
  assign busy    = ~idle;
  assign loading = loading_reg;
  assign dirty   = dirty_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_nvram_sd_sync.sv
// tb_nvram_sd_sync
//   Self-checking bench for nvram_sd_sync (64 sectors, 100-cycle ack timeout).
//   A transaction-level model predicts every output on every cycle. It keeps
//   track of which transfer is active, which sector is current, whether a
//   request is outstanding and since which cycle, and the dirty/err flags.
//   An ack responder plays the hps_io side. Directed scenarios are followed
//   by a randomized phase.

module tb_nvram_sd_sync;

  localparam int          SB   = 6;
  localparam int          NSEC = 1 << SB;
  localparam logic [23:0] TO   = 24'd100;

  logic        clk_sys    = 1'b0;
  logic        reset      = 1'b1;
  logic        bk_ena     = 1'b0;
  logic        mount_done = 1'b0;
  logic        load_req   = 1'b0;
  logic        save_req   = 1'b0;
  logic        osd_open   = 1'b0;
  logic        nv_we      = 1'b0;
  logic        sd_ack     = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, dirty, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_sd_sync #(.SECTOR_BITS(SB), .AUTOSAVE(1), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .mount_done(mount_done),
    .load_req(load_req), .save_req(save_req), .osd_open(osd_open), .nv_we(nv_we),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .busy(busy),
    .loading(loading), .dirty(dirty), .err(err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;
  bit m_active, m_is_load, m_req_out, m_dirty, m_err;
  int m_sector, m_req_since;
  bit p_load, p_save, p_osd, p_ack;

  task automatic model_step();
    bit le, se, oe, ar, af, write_counts;
    cyc++;
    le = (load_req & bk_ena) && !p_load;
    se = (save_req & bk_ena) && !p_save;
    oe = osd_open && !p_osd;
    ar = sd_ack && !p_ack;
    af = !sd_ack && p_ack;
    write_counts = nv_we && !(m_active && m_is_load);
    if (reset) begin
      m_active = 0; m_is_load = 0; m_req_out = 0; m_dirty = 0; m_err = 0;
      m_sector = 0; m_req_since = 0;
    end else begin
      if (!m_active) begin
        if ((mount_done && bk_ena) || le || se || (oe && m_dirty && bk_ena)) begin
          m_is_load   = (mount_done && bk_ena) || le;
          m_active    = 1;
          m_req_out   = 1;
          m_sector    = 0;
          m_err       = 0;
          m_req_since = cyc;
          if (!m_is_load) m_dirty = 0;
        end
      end else if (m_req_out) begin
        if (ar) m_req_out = 0;
        else if (cyc - m_req_since == int'(TO)) begin
          m_req_out = 0; m_active = 0; m_err = 1;
        end
      end else if (af) begin
        if (m_sector == NSEC - 1) begin
          m_active = 0;
          if (m_is_load) m_dirty = 0;
        end else begin
          m_sector++;
          m_req_out   = 1;
          m_req_since = cyc;
        end
      end
      if (write_counts) m_dirty = 1;
    end
    p_load = load_req & bk_ena;
    p_save = save_req & bk_ena;
    p_osd  = osd_open;
    p_ack  = sd_ack;
  endtask

  always @(posedge clk_sys) begin
    model_step();
    #1;
    chk("sd_rd",   sd_rd,   m_active && m_req_out && m_is_load);
    chk("sd_wr",   sd_wr,   m_active && m_req_out && !m_is_load);
    chk("busy",    busy,    m_active);
    chk("loading", loading, m_active && m_is_load);
    chk("dirty",   dirty,   m_dirty);
    chk("err",     err,     m_err);
    chk("sd_lba",  sd_lba,  32'(m_sector));
    chk("rd_wr_exclusive", sd_rd & sd_wr, 1'b0);
  end

  // ---------------- hps_io ack responder ----------------
  bit ack_en    = 1;
  bit rand_ack  = 0;
  int n_rd = 0, n_wr = 0;
  int lba_log[$];

  always begin
    @(negedge clk_sys);
    if (ack_en && !reset && (sd_rd || sd_wr)) begin
      if (sd_rd) n_rd++; else n_wr++;
      lba_log.push_back(int'(sd_lba));
      repeat (rand_ack ? $urandom_range(1, 5) : 3) @(negedge clk_sys);
      sd_ack = 1'b1;
      repeat (rand_ack ? $urandom_range(1, 12) : 10) @(negedge clk_sys);
      sd_ack = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic clear_log();
    n_rd = 0; n_wr = 0;
    lba_log.delete();
  endtask

  task automatic wait_idle(string name, int budget);
    int i = 0;
    while (busy && i < budget) begin tick(); i++; end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_lba(string name, int lba, int budget);
    int i = 0;
    while (sd_lba != 32'(lba) && i < budget) begin tick(); i++; end
    chk({name, "_reach_lba"}, sd_lba, 32'(lba));
  endtask

  task automatic check_xfer(string name, int exp_rd, int exp_wr);
    bit seq_ok = 1;
    chk({name, "_rd_sectors"}, 32'(n_rd), 32'(exp_rd));
    chk({name, "_wr_sectors"}, 32'(n_wr), 32'(exp_wr));
    if (lba_log.size() != exp_rd + exp_wr) seq_ok = 0;
    else foreach (lba_log[i]) if (lba_log[i] != i) seq_ok = 0;
    chk({name, "_lba_sequence"}, seq_ok, 1'b1);
    clear_log();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset state
    bk_ena = 1; reset = 1;
    tick(3);
    chk("rst_busy", busy, 1'b0);  chk("rst_rd", sd_rd, 1'b0);   chk("rst_wr", sd_wr, 1'b0);
    chk("rst_lba", sd_lba, 32'd0); chk("rst_dirty", dirty, 1'b0); chk("rst_err", err, 1'b0);
    reset = 0;
    tick(2);

    // 1: auto-load on mount_done
    mount_done = 1; tick(); mount_done = 0;
    chk("t1_loading_start", loading, 1'b1);
    chk("t1_rd_start", sd_rd, 1'b1);
    wait_idle("t1", 3000);
    check_xfer("t1", 64, 0);
    chk("t1_last_lba", sd_lba, 32'd63);
    chk("t1_loading_end", loading, 1'b0);

    // 2: manual save, with a write during the transfer
    nv_we = 1; tick(); nv_we = 0; tick();
    chk("t2_dirty_set", dirty, 1'b1);
    save_req = 1; tick();
    chk("t2_dirty_cleared", dirty, 1'b0);
    chk("t2_wr_start", sd_wr, 1'b1);
    wait_lba("t2", 20, 2000);
    nv_we = 1; tick(); nv_we = 0;
    wait_idle("t2", 3000);
    check_xfer("t2", 0, 64);
    chk("t2_dirty_end", dirty, 1'b1);
    chk("t2_last_lba", sd_lba, 32'd63);
    save_req = 0; tick();

    // 3: autosave on osd_open while dirty, then the non-triggering cases
    osd_open = 1; tick();
    chk("t3_wr_start", sd_wr, 1'b1);
    wait_idle("t3", 3000);
    check_xfer("t3", 0, 64);
    chk("t3_dirty_end", dirty, 1'b0);
    osd_open = 0; tick(2);
    osd_open = 1; tick(20);
    check_xfer("t3_clean", 0, 0);
    osd_open = 0; nv_we = 1; tick(); nv_we = 0; bk_ena = 0; tick();
    osd_open = 1; tick(20);
    check_xfer("t3_noena", 0, 0);
    chk("t3_dirty_kept", dirty, 1'b1);
    osd_open = 0; bk_ena = 1; tick(2);

    // 4: timeout with no ack, then a normal save clears err
    ack_en = 0;
    load_req = 1; tick();
    cnt = 0;
    while (sd_rd && cnt < 300) begin cnt++; tick(); end
    chk("t4_rd_cycles", 32'(cnt), 32'd100);
    chk("t4_err", err, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_loading", loading, 1'b0);
    chk("t4_dirty_kept", dirty, 1'b1);
    load_req = 0; ack_en = 1; tick(2);
    save_req = 1; tick();
    chk("t4_err_cleared", err, 1'b0);
    wait_idle("t4", 3000);
    check_xfer("t4", 0, 64);
    save_req = 0; tick(2);

    // 5: simultaneous load and save edges; a save toggle during the load is dropped
    load_req = 1; save_req = 1; tick();
    chk("t5_rd", sd_rd, 1'b1);
    chk("t5_wr", sd_wr, 1'b0);
    wait_lba("t5", 10, 2000);
    save_req = 0; tick(3); save_req = 1;
    wait_idle("t5", 3000);
    tick(20);
    check_xfer("t5", 64, 0);
    load_req = 0; save_req = 0; tick(2);

    // 6: reset in the middle of sector 2 aborts; the next load is complete
    load_req = 1; tick();
    wait_lba("t6", 2, 500);
    tick();
    reset = 1; tick();
    chk("t6_rd", sd_rd, 1'b0);    chk("t6_wr", sd_wr, 1'b0);
    chk("t6_busy", busy, 1'b0);   chk("t6_lba", sd_lba, 32'd0);
    reset = 0; load_req = 0;
    tick(30);
    clear_log();
    load_req = 1; tick();
    wait_idle("t6", 3000);
    check_xfer("t6", 64, 0);
    load_req = 0; tick(2);

    // Randomized phase: the per-cycle model does all of the checking here.
    rand_ack = 1;
    for (int i = 0; i < 25000; i++) begin
      nv_we      = ($urandom_range(0, 19) == 0);
      mount_done = ($urandom_range(0, 2999) == 0);
      reset      = ($urandom_range(0, 7999) == 0);
      if ($urandom_range(0, 1499) == 0) load_req = ~load_req;
      if ($urandom_range(0, 1499) == 0) save_req = ~save_req;
      if ($urandom_range(0, 399) == 0)  osd_open = ~osd_open;
      if (bk_ena) begin
        if ($urandom_range(0, 1999) == 0) bk_ena = 0;
      end else if ($urandom_range(0, 199) == 0) bk_ena = 1;
      tick();
    end
    nv_we = 0; mount_done = 0; reset = 0;
    tick(5);
    clear_log();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
